// File: rtl/keypad_reader.sv
// keypad_reader: scans the eight Game Boy buttons through an external 74HC165,
// debounces each one and presents an active-high key[7:0] vector.
// Bit map: 0 right, 1 left, 2 up, 3 down, 4 A, 5 B, 6 select, 7 start.
// Optional macro KEYPAD_SOCD_EN: when defined, opposing directions pressed
// together (right+left, up+down) are both reported released.
// Output pulses: key_changed and scan_done are single-cycle strobes with no
// back-pressure; they fire in the cycle key is (re)written after each scan.
module keypad_reader #(
  parameter int CLK_DIV     = 4,
  parameter int SCAN_PERIOD = 12000,
  parameter int DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sr_load_n,
  output logic       sr_clk,
  input  logic       sr_data,
  output logic [7:0] key,
  output logic       key_changed,
  output logic       scan_done,
  output logic [1:0] dbg_state
);

  localparam int TW = $clog2(SCAN_PERIOD) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(SCAN_PERIOD - 1);
  localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [DW-1:0]   r_div;
  logic [2:0]      r_bit;
  logic            r_phase_hi;
  logic [7:0]      r_raw;
  logic [7:0]      r_deb;
  logic [CW-1:0]   r_cnt [8];

  logic [7:0]      w_deb_next;
  logic [7:0]      w_key_next;
  logic [CW-1:0]   w_cnt_next [8];

  assign dbg_state = r_state;

  // Per-bit debounce: a bit flips only after DEBOUNCE consecutive disagreeing scans.
  always_comb begin
    w_deb_next = r_deb;
    for (int i = 0; i < 8; i++) begin
      w_cnt_next[i] = '0;
      if (r_raw[i] != r_deb[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_deb_next[i] = r_raw[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Output cleaning of the debounced value (opposing directions cancel when enabled).
  always_comb begin
    w_key_next = w_deb_next;
`ifdef KEYPAD_SOCD_EN
    if (w_deb_next[0] && w_deb_next[1]) w_key_next[1:0] = 2'b00;
    if (w_deb_next[2] && w_deb_next[3]) w_key_next[3:2] = 2'b00;
`else
`endif
  end

  // Scan FSM: wait, parallel-load, clock out 8 bits, then commit debounced keys.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_div       <= '0;
      r_bit       <= '0;
      r_phase_hi  <= 1'b0;
      r_raw       <= '0;
      r_deb       <= '0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
      sr_load_n   <= 1'b1;
      sr_clk      <= 1'b0;
      key         <= '0;
      key_changed <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      key_changed <= 1'b0;
      scan_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          sr_load_n <= 1'b1;
          sr_clk    <= 1'b0;
          if (r_timer == TIMER_MAX) begin
            r_timer   <= '0;
            r_div     <= '0;
            sr_load_n <= 1'b0;
            r_state   <= LOAD;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        LOAD: begin
          // QH presents input H (start) once the load is released.
          if (r_div == DIV_MAX) begin
            r_div      <= '0;
            r_bit      <= '0;
            r_phase_hi <= 1'b0;
            sr_load_n  <= 1'b1;
            r_state    <= SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        SHIFT: begin
          if (r_div != DIV_MAX) begin
            r_div <= r_div + 1'b1;
          end else if (!r_phase_hi) begin
            // End of low phase: sample QH (active-low button), MSB first.
            r_div <= '0;
            r_raw <= {r_raw[6:0], ~sr_data};
            if (r_bit == 3'd7) begin
              r_state <= UPDATE;
            end else begin
              r_phase_hi <= 1'b1;
              sr_clk     <= 1'b1;
            end
          end else begin
            r_div      <= '0;
            r_phase_hi <= 1'b0;
            sr_clk     <= 1'b0;
            r_bit      <= r_bit + 1'b1;
          end
        end
        UPDATE: begin
          r_deb       <= w_deb_next;
          for (int i = 0; i < 8; i++) r_cnt[i] <= w_cnt_next[i];
          key         <= w_key_next;
          key_changed <= (w_key_next != key);
          scan_done   <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
